// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N requesters, the round-robin mux arbiter and its
// single downstream consumer.
//   req_valid/req_last/req_data : requester beats (slice i at [DATA_WIDTH*i +: DATA_WIDTH])
//   req_ready                   : one-hot-or-zero accept back to the requesters
//   out_valid/out_data/out_sel/out_last : registered output beat
//   out_ready                   : downstream accept
// master: the side that drives requests and consumes the output beat.
// slave : the arbiter.
interface rr_mux_arbiter_if #(
   parameter int unsigned SEL_WIDTH  = 2,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned N = 1 << SEL_WIDTH;

   logic [N-1:0]            req_valid;
   logic [N-1:0]            req_last;
   logic [DATA_WIDTH*N-1:0] req_data;
   logic [N-1:0]            req_ready;
   logic                    out_valid;
   logic [DATA_WIDTH-1:0]   out_data;
   logic [SEL_WIDTH-1:0]    out_sel;
   logic                    out_last;
   logic                    out_ready;

   modport master (
      output req_valid, req_last, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_sel, out_last
   );

   modport slave (
      input  req_valid, req_last, req_data, out_ready,
      output req_ready, out_valid, out_data, out_sel, out_last
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one mux datapath among 2**SEL_WIDTH requesters.
// The granted beat is registered into a single valid/ready output stage;
// multi-beat bursts keep the grant until the beat marked last is accepted.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : request streams in, registered output stream out (slave modport)
//   locked : high while a burst holds the grant
module rr_mux_arbiter #(
   parameter int unsigned SEL_WIDTH  = 2,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   rr_mux_arbiter_if.slave bus,
   output logic            locked
);
   localparam int unsigned N = 1 << SEL_WIDTH;

   typedef enum logic {StArb, StLock} state_e;

   state_e                state_q;
   logic [SEL_WIDTH-1:0]  ptr_q;
   logic [SEL_WIDTH-1:0]  lock_id_q;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [SEL_WIDTH-1:0]  out_sel_q;
   logic                  out_last_q;

   logic                  load_en;
   logic [SEL_WIDTH-1:0]  grant;
   logic                  grant_vld;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] grant_data;

   // Output stage can take a new beat when empty or being drained this cycle.
   assign load_en = !out_valid_q || bus.out_ready;

   // Search from ptr upward with wrap; iterating from the far end means the
   // closest valid requester to ptr writes last and wins.
   always_comb begin
      grant     = ptr_q;
      grant_vld = 1'b0;
      if (state_q == StLock) begin
         grant     = lock_id_q;
         grant_vld = bus.req_valid[lock_id_q];
      end else begin
         for (int k = int'(N) - 1; k >= 0; k--) begin
            if (bus.req_valid[ptr_q + SEL_WIDTH'(k)]) begin
               grant     = ptr_q + SEL_WIDTH'(k);
               grant_vld = 1'b1;
            end
         end
      end
   end

   assign grant_data    = bus.req_data[DATA_WIDTH*grant +: DATA_WIDTH];
   assign xfer          = rst_n && load_en && grant_vld;
   assign bus.req_ready = xfer ? (N'(1) << grant) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StArb;
         ptr_q       <= '0;
         lock_id_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (load_en) begin
         out_valid_q <= xfer;
         if (xfer) begin
            out_data_q <= grant_data;
            out_sel_q  <= grant;
            out_last_q <= bus.req_last[grant];
            if (bus.req_last[grant]) begin
               // In LOCK the grant equals lock_id, so both states advance the same way.
               state_q <= StArb;
               ptr_q   <= grant + 1'b1;
            end else if (state_q == StArb) begin
               state_q   <= StLock;
               lock_id_q <= grant;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_last  = out_last_q;
   assign locked        = (state_q == StLock);
endmodule
